// File: rtl/grid_pixel_pipeline_if.sv
// Pixel-stream bundle between the VGA timing side, the board memory and the renderer.
// de_in qualifies each pixel and there is no backpressure: the renderer accepts one pixel every clock.
interface grid_pixel_pipeline_if #(
    parameter int STATE_W = 12
);
    logic [9:0]         x;
    logic [9:0]         y;
    logic               de_in;
    logic               hsync_in;
    logic               vsync_in;
    logic [7:0]         cell_addr;
    logic [STATE_W-1:0] cell_data;
    logic [3:0]         cur_col;
    logic [3:0]         cur_row;
    logic [7:0]         red;
    logic [7:0]         green;
    logic [7:0]         blue;
    logic               de_out;
    logic               hsync_out;
    logic               vsync_out;

    modport master (
        output x, y, de_in, hsync_in, vsync_in, cell_data, cur_col, cur_row,
        input  cell_addr, red, green, blue, de_out, hsync_out, vsync_out
    );

    modport slave (
        input  x, y, de_in, hsync_in, vsync_in, cell_data, cur_col, cur_row,
        output cell_addr, red, green, blue, de_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/grid_pixel_pipeline.sv
// Three-stage VGA board renderer: incremental cell tracking, board memory lookup, RGB888 out.
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module grid_pixel_pipeline #(
    parameter int COLS         = 10,
    parameter int ROWS         = 10,
    parameter int CELL_W       = 62,
    parameter int CELL_H       = 46,
    parameter int ORIGIN_X     = 10,
    parameter int ORIGIN_Y     = 10,
    parameter int LINE_W       = 5,
    parameter int STATE_W      = 12,
    parameter int DIVIDER_COL  = 5,
    parameter int BLINK_FRAMES = 30
) (
    input logic                  clk,
    input logic                  rst_n,
    grid_pixel_pipeline_if.slave bus
);

    localparam int XW    = $clog2(CELL_W);
    localparam int YW    = $clog2(CELL_H);
    localparam int X_END = ORIGIN_X + COLS * CELL_W + LINE_W;
    localparam int Y_END = ORIGIN_Y + ROWS * CELL_H + LINE_W;

    typedef enum logic [2:0] {
        CLS_OUT,
        CLS_DIV,
        CLS_LINE,
        CLS_CURSOR,
        CLS_CELL
    } pix_cls_t;

    logic [31:0]   x_w;
    logic [31:0]   y_w;
    logic          frame_start;

    logic [XW-1:0] col_off_q, col_off_c;
    logic [4:0]    col_idx_q, col_idx_c;
    logic [YW-1:0] row_off_q, row_off_c;
    logic [4:0]    row_idx_q, row_idx_c;
    logic          synced_q, synced_c;
    logic [3:0]    cur_col_q, cur_row_q;

    logic          in_x, in_y;
    logic          col_line, row_line, closing_line;
    logic          divider_hit, cursor_ok, cursor_hit;
    pix_cls_t      cls_c, cls1, cls2;
    logic [7:0]    addr_c;

    logic [2:0]    de_pipe, hs_pipe, vs_pipe;
    logic [23:0]   rgb_c;
    logic [3:0]    r4, g4, b4;
    logic          cursor_visible;

    assign x_w         = {22'd0, bus.x};
    assign y_w         = {22'd0, bus.y};
    assign frame_start = bus.de_in && (bus.x == 10'd0) && (bus.y == 10'd0);

    // The *_c values describe the pixel currently on x/y; the *_q registers hold the previous one.
    always_comb begin
        col_off_c = col_off_q;
        col_idx_c = col_idx_q;
        if (bus.de_in) begin
            if (x_w == ORIGIN_X) begin
                col_off_c = '0;
                col_idx_c = '0;
            end else if (col_off_q == XW'(CELL_W - 1)) begin
                col_off_c = '0;
                col_idx_c = col_idx_q + 5'd1;
            end else begin
                col_off_c = col_off_q + XW'(1);
            end
        end
    end

    always_comb begin
        row_off_c = row_off_q;
        row_idx_c = row_idx_q;
        if (bus.de_in && (bus.x == 10'd0)) begin
            if (y_w == ORIGIN_Y) begin
                row_off_c = '0;
                row_idx_c = '0;
            end else if (row_off_q == YW'(CELL_H - 1)) begin
                row_off_c = '0;
                row_idx_c = row_idx_q + 5'd1;
            end else begin
                row_off_c = row_off_q + YW'(1);
            end
        end
    end

    // Counters are meaningless after a mid-frame reset until the next frame start.
    assign synced_c = synced_q | frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_off_q <= '0;
            col_idx_q <= '0;
            row_off_q <= '0;
            row_idx_q <= '0;
            synced_q  <= 1'b0;
            cur_col_q <= '0;
            cur_row_q <= '0;
        end else begin
            col_off_q <= col_off_c;
            col_idx_q <= col_idx_c;
            row_off_q <= row_off_c;
            row_idx_q <= row_idx_c;
            synced_q  <= synced_c;
            if (frame_start) begin
                cur_col_q <= bus.cur_col;
                cur_row_q <= bus.cur_row;
            end
        end
    end

    // Stage 1 classification of the current pixel.
    always_comb begin
        in_x         = (x_w >= ORIGIN_X) && (x_w < X_END);
        in_y         = (y_w >= ORIGIN_Y) && (y_w < Y_END);
        col_line     = 32'(col_off_c) < LINE_W;
        row_line     = 32'(row_off_c) < LINE_W;
        closing_line = (32'(col_idx_c) == COLS) || (32'(row_idx_c) == ROWS);
        divider_hit  = (DIVIDER_COL != 0) && (32'(col_idx_c) == DIVIDER_COL) && col_line;
        cursor_ok    = (32'(cur_col_q) < COLS) && (32'(cur_row_q) < ROWS);
        cursor_hit   = cursor_ok
                    && (col_idx_c == {1'b0, cur_col_q})
                    && (row_idx_c == {1'b0, cur_row_q})
                    && ((32'(col_off_c) < 2 * LINE_W) || (32'(col_off_c) >= CELL_W - LINE_W)
                     || (32'(row_off_c) < 2 * LINE_W) || (32'(row_off_c) >= CELL_H - LINE_W));
        addr_c       = 8'(32'(row_idx_c) * COLS + 32'(col_idx_c));

        cls_c = CLS_CELL;
        if (!bus.de_in || !synced_c || !in_x || !in_y) begin
            cls_c = CLS_OUT;
        end else if (divider_hit) begin
            cls_c = CLS_DIV;
        end else if (col_line || row_line || closing_line) begin
            cls_c = CLS_LINE;
        end else if (cursor_hit) begin
            cls_c = CLS_CURSOR;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_vis;
    logic          cursor_moved;

    assign cursor_moved   = (bus.cur_col != cur_col_q) || (bus.cur_row != cur_row_q);
    assign cursor_visible = blink_vis;

    // The first frame after reset and every cursor move restart the blink with the cursor shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (frame_start) begin
            if (!synced_q || cursor_moved) begin
                blink_cnt <= '0;
                blink_vis <= 1'b1;
            end else if (32'(blink_cnt) + 1 == BLINK_FRAMES) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end
`else
    assign cursor_visible = 1'b1;
`endif

    // Stage 3 colour; cell_data arrives for the pixel now held in stage 2.
    assign r4 = bus.cell_data[STATE_W-1 -: 4];
    assign g4 = bus.cell_data[STATE_W-5 -: 4];
    assign b4 = bus.cell_data[STATE_W-9 -: 4];

    always_comb begin
        rgb_c = 24'h000000;
        case (cls2)
            CLS_OUT:    rgb_c = 24'h000000;
            CLS_DIV:    rgb_c = 24'h00FF00;
            CLS_LINE:   rgb_c = 24'hFFFFFF;
            CLS_CURSOR: rgb_c = cursor_visible ? 24'hFFFF00 : {r4, r4, g4, g4, b4, b4};
            CLS_CELL:   rgb_c = {r4, r4, g4, g4, b4, b4};
            default:    rgb_c = 24'h000000;
        endcase
        if (!de_pipe[1]) begin
            rgb_c = 24'h000000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls1          <= CLS_OUT;
            cls2          <= CLS_OUT;
            bus.cell_addr <= '0;
            de_pipe       <= 3'b000;
            hs_pipe       <= 3'b111;
            vs_pipe       <= 3'b111;
            bus.red       <= '0;
            bus.green     <= '0;
            bus.blue      <= '0;
        end else begin
            cls1          <= cls_c;
            bus.cell_addr <= addr_c;
            cls2          <= cls1;
            de_pipe       <= {de_pipe[1:0], bus.de_in};
            hs_pipe       <= {hs_pipe[1:0], bus.hsync_in};
            vs_pipe       <= {vs_pipe[1:0], bus.vsync_in};
            bus.red       <= rgb_c[23:16];
            bus.green     <= rgb_c[15:8];
            bus.blue      <= rgb_c[7:0];
        end
    end

    assign bus.de_out    = de_pipe[2];
    assign bus.hsync_out = hs_pipe[2];
    assign bus.vsync_out = vs_pipe[2];

endmodule

// File: tb/tb_grid_pixel_pipeline.sv
// Directed bench for grid_pixel_pipeline with default parameters and a synchronous board memory model.
module tb_grid_pixel_pipeline;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [11:0] mem [256];

    always #20 clk = ~clk;

    grid_pixel_pipeline_if #(.STATE_W(12)) bus ();

    grid_pixel_pipeline dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Board memory: data valid one clock after the address.
    always @(posedge clk) bus.cell_data <= mem[bus.cell_addr];

    task automatic drive(input int px, input int py, input logic de, input logic hs);
        @(negedge clk);
        bus.x        = 10'(px);
        bus.y        = 10'(py);
        bus.de_in    = de;
        bus.hsync_in = hs;
        bus.vsync_in = 1'b1;
    endtask

    // One frame: frame start, the x=0 pixel of each line, then the target line up to px.
    task automatic show_pixel(input int px, input int py, output logic [23:0] rgb, output logic [7:0] addr);
        drive(0, 0, 1'b1, 1'b1);
        for (int l = 1; l <= py; l++) drive(0, l, 1'b1, 1'b1);
        if (px >= 10) begin
            for (int c = 10; c <= px; c++) drive(c, py, 1'b1, 1'b1);
        end else if (px != 0) begin
            drive(px, py, 1'b1, 1'b1);
        end
        drive(700, 500, 1'b0, 1'b1);
        addr = bus.cell_addr;
        drive(700, 500, 1'b0, 1'b1);
        @(negedge clk);
        rgb = {bus.red, bus.green, bus.blue};
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.red, bus.green, bus.blue} !== 24'h000000) begin
            errors++; $display("FAIL reset_rgb: got %h expected 000000", {bus.red, bus.green, bus.blue});
        end
        checks++;
        if ({bus.de_out, bus.hsync_out, bus.vsync_out} !== 3'b011) begin
            errors++; $display("FAIL reset_sync: got %b expected 011", {bus.de_out, bus.hsync_out, bus.vsync_out});
        end
        checks++;
        if (bus.cell_addr !== 8'd0) begin
            errors++; $display("FAIL reset_addr: got %0d expected 0", bus.cell_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_grid_line;
        drive(0, 0, 1'b1, 1'b1);
        for (int l = 1; l <= 20; l++) drive(0, l, 1'b1, 1'b1);
        repeat (3) drive(700, 500, 1'b0, 1'b1);
        drive(10, 20, 1'b1, 1'b0);
        drive(700, 500, 1'b0, 1'b1);
        drive(700, 500, 1'b0, 1'b1);
        checks++;
        if ({bus.de_out, bus.hsync_out} !== 2'b01) begin
            errors++; $display("FAIL line_early: got de/hs %b expected 01", {bus.de_out, bus.hsync_out});
        end
        @(negedge clk);
        checks++;
        if ({bus.red, bus.green, bus.blue} !== 24'hFFFFFF) begin
            errors++; $display("FAIL line_rgb: got %h expected FFFFFF", {bus.red, bus.green, bus.blue});
        end
        checks++;
        if ({bus.de_out, bus.hsync_out} !== 2'b10) begin
            errors++; $display("FAIL line_aligned: got de/hs %b expected 10", {bus.de_out, bus.hsync_out});
        end
        @(negedge clk);
        checks++;
        if ({bus.de_out, bus.red, bus.green, bus.blue} !== 25'd0) begin
            errors++; $display("FAIL line_after: got de %b rgb %h expected 0 000000", bus.de_out, {bus.red, bus.green, bus.blue});
        end
    endtask

    task automatic test_cell_colour;
        int          tx [3];
        int          ty [3];
        logic [23:0] te [3];
        logic [7:0]  ta [3];
        logic [23:0] rgb;
        logic [7:0]  addr;
        tx = '{77, 20, 598};
        ty = '{61, 20, 444};
        te = '{24'hFF0000, 24'h55AA33, 24'h00CC99};
        ta = '{8'd11, 8'd0, 8'd99};
        for (int i = 0; i < 3; i++) begin
            show_pixel(tx[i], ty[i], rgb, addr);
            checks++;
            if (addr !== ta[i]) begin
                errors++; $display("FAIL cell_addr(%0d,%0d): got %0d expected %0d", tx[i], ty[i], addr, ta[i]);
            end
            checks++;
            if (rgb !== te[i]) begin
                errors++; $display("FAIL cell_rgb(%0d,%0d): got %h expected %h", tx[i], ty[i], rgb, te[i]);
            end
        end
    endtask

    task automatic test_divider_outside;
        int          tx [4];
        int          ty [4];
        logic [23:0] te [4];
        logic [23:0] rgb;
        logic [7:0]  addr;
        tx = '{320, 322, 258, 5};
        ty = '{100, 10, 100, 100};
        te = '{24'h00FF00, 24'h00FF00, 24'hFFFFFF, 24'h000000};
        for (int i = 0; i < 4; i++) begin
            show_pixel(tx[i], ty[i], rgb, addr);
            checks++;
            if (rgb !== te[i]) begin
                errors++; $display("FAIL divider(%0d,%0d): got %h expected %h", tx[i], ty[i], rgb, te[i]);
            end
        end
    endtask

    task automatic test_boundaries;
        int          tx [5];
        int          ty [5];
        logic [23:0] te [5];
        logic [23:0] rgb;
        logic [7:0]  addr;
        tx = '{634, 635, 77, 77, 10};
        ty = '{100, 100, 474, 475, 10};
        te = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        for (int i = 0; i < 5; i++) begin
            show_pixel(tx[i], ty[i], rgb, addr);
            checks++;
            if (rgb !== te[i]) begin
                errors++; $display("FAIL edge(%0d,%0d): got %h expected %h", tx[i], ty[i], rgb, te[i]);
            end
        end
    endtask

    task automatic test_cursor;
        int          tx [6];
        int          ty [6];
        int          tc [6];
        int          tr [6];
        logic [23:0] te [6];
        logic [23:0] rgb;
        logic [7:0]  addr;
        tx = '{139, 191, 164, 164, 139, 139};
        ty = '{168, 168, 154, 168, 168, 168};
        tc = '{2, 2, 2, 2, 12, 2};
        tr = '{3, 3, 3, 3, 3, 10};
        te = '{24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'h33AA77, 24'h33AA77, 24'h33AA77};
        for (int i = 0; i < 6; i++) begin
            bus.cur_col = 4'(tc[i]);
            bus.cur_row = 4'(tr[i]);
            show_pixel(tx[i], ty[i], rgb, addr);
            checks++;
            if (rgb !== te[i]) begin
                errors++; $display("FAIL cursor(%0d,%0d) cur=%0d,%0d: got %h expected %h",
                                   tx[i], ty[i], tc[i], tr[i], rgb, te[i]);
            end
        end
        bus.cur_col = 4'd2;
        bus.cur_row = 4'd3;
    endtask

    task automatic test_reset_mid_line;
        logic [23:0] rgb;
        logic [7:0]  addr;
        drive(0, 0, 1'b1, 1'b1);
        for (int l = 1; l <= 20; l++) drive(0, l, 1'b1, 1'b1);
        for (int c = 10; c <= 15; c++) drive(c, 20, 1'b1, 1'b1);
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.red, bus.green, bus.blue} !== 24'h000000) begin
            errors++; $display("FAIL midreset_rgb: got %h expected 000000", {bus.red, bus.green, bus.blue});
        end
        checks++;
        if ({bus.de_out, bus.hsync_out, bus.vsync_out} !== 3'b011) begin
            errors++; $display("FAIL midreset_sync: got %b expected 011", {bus.de_out, bus.hsync_out, bus.vsync_out});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 21, 1'b1, 1'b1);
        drive(0, 22, 1'b1, 1'b1);
        drive(10, 22, 1'b1, 1'b1);
        drive(700, 500, 1'b0, 1'b1);
        drive(700, 500, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.red, bus.green, bus.blue} !== 24'h000000) begin
            errors++; $display("FAIL unsynced_rgb: got %h expected 000000", {bus.red, bus.green, bus.blue});
        end
        show_pixel(10, 20, rgb, addr);
        checks++;
        if (rgb !== 24'hFFFFFF) begin
            errors++; $display("FAIL resync_rgb: got %h expected FFFFFF", rgb);
        end
    endtask

`ifdef CURSOR_BLINK_EN
    task automatic test_blink;
        logic [23:0] rgb;
        logic [7:0]  addr;
        logic [23:0] exp_rgb;
        int          py;
        @(negedge clk);
        rst_n = 1'b0;
        bus.cur_col = 4'd2;
        bus.cur_row = 4'd3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 60; f++) begin
            py = (f >= 36) ? 214 : 168;
            if (f < 30)      exp_rgb = 24'hFFFF00;
            else if (f < 36) exp_rgb = 24'h33AA77;
            else             exp_rgb = 24'hFFFF00;
            show_pixel(139, py, rgb, addr);
            checks++;
            if (rgb !== exp_rgb) begin
                errors++; $display("FAIL blink frame %0d: got %h expected %h", f, rgb, exp_rgb);
            end
            if (f == 35) bus.cur_row = 4'd4;
        end
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        mem[0]  = 12'h5A3;
        mem[11] = 12'hF00;
        mem[32] = 12'h3A7;
        mem[42] = 12'h8C1;
        mem[99] = 12'h0C9;
        rst_n        = 1'b0;
        bus.x        = 10'd700;
        bus.y        = 10'd500;
        bus.de_in    = 1'b0;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        bus.cur_col  = 4'd2;
        bus.cur_row  = 4'd3;

        test_reset;
        test_grid_line;
        test_cell_colour;
        test_divider_outside;
        test_boundaries;
        test_cursor;
        test_reset_mid_line;
`ifdef CURSOR_BLINK_EN
        test_blink;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
